// File: rtl/ula_pkg.sv
// Shared opcode, FSM state and flag types for the sequential ULA.
package ula_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_MUL = 3'b101,
      OP_DIV = 3'b110,
      OP_CMP = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
      logic e;
   } flags_t;

   function automatic logic is_iterative(input op_e op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/ula_seq_if.sv
// Operand/opcode request channel and result/flag response channel of ula_seq.
interface ula_seq_if #(parameter int WIDTH = 8);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2:0]           opcode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   s;
   logic                 flag_z;
   logic                 flag_c;
   logic                 flag_n;
   logic                 flag_v;
   logic                 flag_e;

   modport master (
      output in_valid, a, b, opcode, out_ready,
      input  in_ready, out_valid, s, flag_z, flag_c, flag_n, flag_v, flag_e
   );

   modport slave (
      input  in_valid, a, b, opcode, out_ready,
      output in_ready, out_valid, s, flag_z, flag_c, flag_n, flag_v, flag_e
   );

endinterface

// File: rtl/ula_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per
// cycle, sharing a single 2*WIDTH accumulator and iteration counter.
module ula_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               is_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o,
   output logic [WIDTH-1:0]   quot_o,
   output logic [WIDTH-1:0]   rem_o,
   output logic               div0_o
);

   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   logic              busy_q;
   logic              div_q;
   logic              div0_q;
   logic [WIDTH-1:0]  b_q;
   logic [W2-1:0]     acc_q;
   logic [CW-1:0]     cnt_q;

   logic [WIDTH:0]    mul_sum;
   logic [W2-1:0]     mul_nxt;
   logic [WIDTH:0]    rem_sh;
   logic              rem_ge;
   logic [WIDTH-1:0]  rem_nx;
   logic [W2-1:0]     div_nxt;

   // Multiply: low half holds the unused multiplier bits, high half the partial sum.
   // Divide: high half is the running remainder, low half shifts dividend out / quotient in.
   always_comb begin
      mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh  = acc_q[W2-1:WIDTH-1];
      rem_ge  = rem_sh >= {1'b0, b_q};
      rem_nx  = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
      div_nxt = {rem_nx, acc_q[WIDTH-2:0], rem_ge};
   end

   assign done_o = busy_q && (cnt_q == CW'(WIDTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         div_q  <= 1'b0;
         div0_q <= 1'b0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         div_q  <= is_div_i;
         div0_q <= (b_i == '0);
         b_q    <= b_i;
         acc_q  <= W2'(a_i);
         cnt_q  <= '0;
      end else if (busy_q) begin
         if (done_o) begin
            busy_q <= 1'b0;
         end else begin
            acc_q <= div_q ? div_nxt : mul_nxt;
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // With b = 0 the restoring loop naturally yields quotient all-ones, remainder a.
   assign prod_o = acc_q;
   assign quot_o = acc_q[WIDTH-1:0];
   assign rem_o  = acc_q[W2-1:WIDTH];
   assign div0_o = div0_q;

endmodule

// File: rtl/ula_seq.sv
// Sequential ULA: valid/ready operand intake, single-cycle logic/arith ops,
// iterative MUL/DIV, registered result and flags held until consumed.
module ula_seq
   import ula_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   ula_seq_if.slave   bus
);

   localparam int W2 = 2 * WIDTH;

   state_e           state_q, state_d;
   op_e              op;
   logic             in_ready, out_valid, accept;
   logic             md_start, load_sc, load_md;
   logic             op_div_q;

   logic [W2-1:0]    s_q;
   flags_t           flg_q;

   logic [WIDTH:0]   add_w, sub_w;
   logic [WIDTH-1:0] lg_w;
   logic [W2-1:0]    sc_s, md_s;
   flags_t           sc_f, md_f;

   logic             md_done, md_div0;
   logic [W2-1:0]    md_prod;
   logic [WIDTH-1:0] md_quot, md_rem;

   assign op = op_e'(bus.opcode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = is_iterative(op) ? S_BUSY : S_DONE;
         S_BUSY: if (md_done) state_d = S_DONE;
         S_DONE: if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      accept    = in_ready && bus.in_valid;
      md_start  = accept && is_iterative(op);
      load_sc   = accept && !is_iterative(op);
      load_md   = (state_q == S_BUSY) && md_done;
   end

   always_comb begin
      add_w = {1'b0, bus.a} + {1'b0, bus.b};
      sub_w = {1'b0, bus.a} - {1'b0, bus.b};
      lg_w  = '0;
      sc_s  = '0;
      sc_f  = '0;
      case (op)
         OP_ADD: begin
            sc_s   = W2'(add_w);
            sc_f.c = add_w[WIDTH];
            sc_f.v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_w[WIDTH-1] != bus.a[WIDTH-1]);
            sc_f.z = (add_w[WIDTH-1:0] == '0);
            sc_f.n = add_w[WIDTH-1];
         end
         OP_SUB, OP_CMP: begin
            // sub_w[WIDTH] is the borrow, so zero-extending places it at s[WIDTH].
            if (op == OP_SUB) sc_s = W2'(sub_w);
            sc_f.c = sub_w[WIDTH];
            sc_f.v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a[WIDTH-1]);
            sc_f.z = (sub_w[WIDTH-1:0] == '0);
            sc_f.n = sub_w[WIDTH-1];
         end
         OP_AND, OP_OR, OP_XOR: begin
            lg_w   = (op == OP_AND) ? (bus.a & bus.b) :
                     (op == OP_OR)  ? (bus.a | bus.b) : (bus.a ^ bus.b);
            sc_s   = W2'(lg_w);
            sc_f.z = (lg_w == '0);
            sc_f.n = lg_w[WIDTH-1];
         end
         default: ;
      endcase
   end

   always_comb begin
      md_s   = op_div_q ? {md_rem, md_quot} : md_prod;
      md_f   = '0;
      md_f.z = op_div_q ? (md_quot == '0) : (md_prod == '0);
      md_f.c = !op_div_q && (md_prod[W2-1:WIDTH] != '0);
      md_f.n = md_s[WIDTH-1];
      md_f.e = op_div_q && md_div0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q      <= '0;
         flg_q    <= '0;
         op_div_q <= 1'b0;
      end else begin
         if (md_start) op_div_q <= (op == OP_DIV);
         if (load_sc) begin
            s_q   <= sc_s;
            flg_q <= sc_f;
         end else if (load_md) begin
            s_q   <= md_s;
            flg_q <= md_f;
         end
      end
   end

   ula_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (md_start),
      .is_div_i (op == OP_DIV),
      .a_i      (bus.a),
      .b_i      (bus.b),
      .done_o   (md_done),
      .prod_o   (md_prod),
      .quot_o   (md_quot),
      .rem_o    (md_rem),
      .div0_o   (md_div0)
   );

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.s         = s_q;
   assign bus.flag_z    = flg_q.z;
   assign bus.flag_c    = flg_q.c;
   assign bus.flag_n    = flg_q.n;
   assign bus.flag_v    = flg_q.v;
   assign bus.flag_e    = flg_q.e;

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq (WIDTH = 8): directed vectors with literal expectations plus
// randomized ops checked against an arithmetic reference model.
module tb_ula_seq;

   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ula_seq_if #(.WIDTH(W)) bus ();
   ula_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] exp_s;
   logic [4:0]  exp_f;
   bit          exp_ok = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int sx(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   // Reference: plain integer arithmetic on the opcode semantics. f = {z,c,n,v,e}.
   function automatic void model(input int op, input int a, input int b,
                                 output logic [15:0] s, output logic [4:0] f);
      int r, lo, sr, q, rm;
      bit z, c, n, v, e;
      z = 0; c = 0; n = 0; v = 0; e = 0; s = '0;
      case (op)
         0: begin
            r = a + b; s = 16'(r); c = (r >= 256); lo = r % 256;
            z = (lo == 0); n = (lo >= 128);
            sr = sx(a) + sx(b); v = (sr > 127) || (sr < -128);
         end
         1, 7: begin
            lo = (a - b + 256) % 256; c = (a < b);
            if (op == 1) s = 16'((c ? 256 : 0) + lo);
            z = (lo == 0); n = (lo >= 128);
            sr = sx(a) - sx(b); v = (sr > 127) || (sr < -128);
         end
         2, 3, 4: begin
            r = (op == 2) ? (a & b) : (op == 3) ? (a | b) : (a ^ b);
            s = 16'(r); z = (r == 0); n = (r >= 128);
         end
         5: begin
            r = a * b; s = 16'(r); c = (r >= 256); z = (r == 0); n = ((r / 128) % 2) == 1;
         end
         default: begin
            if (b == 0) begin q = 255; rm = a; e = 1; end
            else begin q = a / b; rm = a % b; end
            s = 16'(rm * 256 + q); z = (q == 0); n = (q >= 128);
         end
      endcase
      f = {z, c, n, v, e};
   endfunction

   function automatic logic [4:0] dut_flags();
      return {bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v, bus.flag_e};
   endfunction

   // Continuous compare of every meaningful output cycle against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid && bus.in_ready) chk("valid_and_ready", 1, 0);
         if (bus.out_valid) begin
            if (!exp_ok) chk("unexpected_out_valid", 1, 0);
            else begin
               chk("mon_s", 32'(bus.s), 32'(exp_s));
               chk("mon_flags", 32'(dut_flags()), 32'(exp_f));
            end
         end
      end
   end

   task automatic do_op(input int op, input int a, input int b, input int hold, input bit poke,
                        output logic [15:0] got_s, output logic [4:0] got_f);
      int k, n;
      got_s = '0; got_f = '0;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.opcode = 3'(op); bus.a = 8'(a); bus.b = 8'(b);
      k = 0;
      while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
      if (!bus.in_ready) begin chk("in_ready_timeout", 0, 1); bus.in_valid = 1'b0; return; end
      @(posedge clk);
      model(op, a, b, exp_s, exp_f);
      exp_ok = 1'b1;
      #1;
      bus.in_valid = 1'b0;
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.opcode = 3'($urandom);
      n = 0;
      do begin @(posedge clk); n++; @(negedge clk); end while (!bus.out_valid && n < 40);
      chk("latency", n, (op == 5 || op == 6) ? W + 1 : 1);
      got_s = bus.s; got_f = dut_flags();
      for (int h = 0; h < hold; h++) begin
         chk("hold_valid", 32'(bus.out_valid), 1);
         chk("hold_in_ready", 32'(bus.in_ready), 0);
         chk("hold_s", 32'(bus.s), 32'(got_s));
         chk("hold_flags", 32'(dut_flags()), 32'(got_f));
         bus.in_valid = poke && (h == 1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk("idle_out_valid", 32'(bus.out_valid), 0);
      chk("idle_in_ready", 32'(bus.in_ready), 1);
      chk("idle_s_retained", 32'(bus.s), 32'(got_s));
   endtask

   initial begin
      logic [15:0] gs;
      logic [4:0]  gf;
      int op, a, b;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.opcode = '0;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_s", 32'(bus.s), 0);
      chk("rst_flags", 32'(dut_flags()), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of a multiply.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.opcode = 3'd5; bus.a = 8'hFF; bus.b = 8'hFF;
      @(posedge clk);
      exp_ok = 1'b0;
      #1 bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midmul_out_valid", 32'(bus.out_valid), 0);
      chk("midmul_in_ready", 32'(bus.in_ready), 1);
      chk("midmul_s", 32'(bus.s), 0);
      chk("midmul_flags", 32'(dut_flags()), 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(0, 8'h01, 8'h01, 0, 0, gs, gf); chk("add_1_1_s", 32'(gs), 32'h0002);
      do_op(0, 8'hFF, 8'h01, 0, 0, gs, gf); chk("add_ff_01_s", 32'(gs), 32'h0100);
      chk("add_ff_01_f", 32'(gf), 32'b11000);
      do_op(0, 8'h7F, 8'h01, 1, 0, gs, gf); chk("add_7f_01_s", 32'(gs), 32'h0080);
      chk("add_7f_01_f", 32'(gf), 32'b00110);
      do_op(1, 8'h03, 8'h05, 0, 0, gs, gf); chk("sub_03_05_lo", 32'(gs[7:0]), 32'hFE);
      chk("sub_03_05_f", 32'(gf), 32'b01100);
      do_op(7, 8'h05, 8'h05, 0, 0, gs, gf); chk("cmp_05_05_s", 32'(gs), 0);
      chk("cmp_05_05_f", 32'(gf), 32'b10000);
      do_op(5, 8'hFF, 8'hFF, 0, 0, gs, gf); chk("mul_ff_ff_s", 32'(gs), 32'hFE01);
      chk("mul_ff_ff_f", 32'(gf), 32'b01000);
      do_op(5, 8'h00, 8'h37, 0, 0, gs, gf); chk("mul_00_37_s", 32'(gs), 0);
      chk("mul_00_37_f", 32'(gf), 32'b10000);
      do_op(6, 8'h64, 8'h07, 0, 0, gs, gf); chk("div_64_07_s", 32'(gs), 32'h020E);
      chk("div_64_07_f", 32'(gf), 32'b00000);
      do_op(6, 8'h2A, 8'h00, 0, 0, gs, gf); chk("div_2a_00_s", 32'(gs), 32'h2AFF);
      chk("div_2a_00_f", 32'(gf), 32'b00101);
      do_op(4, 8'hF0, 8'h3C, 5, 1, gs, gf); chk("xor_hold_s", 32'(gs), 32'h00CC);
      chk("xor_hold_f", 32'(gf), 32'b00100);

      for (int i = 0; i < 80; i++) begin
         op = $urandom_range(0, 7);
         a  = $urandom_range(0, 255);
         b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
         do_op(op, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)), gs, gf);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
